// File: rtl/conditional_split.sv
// Versat data-flow demux: routes each word on in1 to out0 or out1 by in0[0]
// and counts the words sent each way since the last run pulse.
module conditional_split #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [31:0]        in0,
  input  logic [DATA_W-1:0]  in1,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [31:0]        out2,
  output logic [31:0]        out3
);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } word_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic               smp, clr;
  word_t              word;

  assign word = '{sel: in0[0], data: in1};

  // only bit 0 of the selector is meaningful
  logic unused_sel;
  assign unused_sel = &{1'b0, in0[31:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // run overrides everything, so a restart mid-WAIT or mid-ACTIVE re-arms cleanly
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    smp     = 1'b0;
    clr     = 1'b0;
    if (run) begin
      clr = 1'b1;
      if (delay0 == '0) begin
        state_d = ACTIVE;
      end else begin
        dcnt_d  = delay0 - DELAY_W'(1);
        state_d = WAIT;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (!running)           state_d = IDLE;
          else if (dcnt_q == '0)  state_d = ACTIVE;
          else                    dcnt_d  = dcnt_q - DELAY_W'(1);
        end
        ACTIVE: begin
          if (!running) state_d = IDLE;
          else          smp     = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
    end else if (clr) begin
      out2 <= '0;
      out3 <= '0;
    end else if (smp) begin
      if (word.sel) begin
        out0 <= word.data;
        out2 <= out2 + 32'd1;
      end else begin
        out1 <= word.data;
        out3 <= out3 + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_conditional_split.sv
// Randomized and directed bench for conditional_split; a cycle-indexed model
// decides which words are sampled from the run cycle, delay and running history.
module tb_conditional_split;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        running = 1'b0;
  logic        run = 1'b0;
  logic [31:0] delay0 = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic [31:0] out0, out1, out2, out3;

  int total = 0;
  int bad = 0;

  conditional_split #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .delay0(delay0),
    .in0(in0), .in1(in1), .out0(out0), .out1(out1), .out2(out2), .out3(out3)
  );

  always #5 clk = ~clk;

  // Model: after run in cycle N with delay D, cycles >= N+1+D are sampled as long
  // as running has stayed high every cycle since N.
  longint      cyc = 0;
  longint      start = 0;
  logic        armed = 1'b0;
  logic [31:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      m0 <= '0; m1 <= '0; m2 <= '0; m3 <= '0;
    end else begin
      if (run) begin
        armed <= 1'b1;
        start <= cyc + 1 + longint'(delay0);
        m2 <= '0; m3 <= '0;
      end else if (armed) begin
        if (!running) armed <= 1'b0;
        else if (cyc >= start) begin
          if (in0[0]) begin m0 <= in1; m2 <= m2 + 32'd1; end
          else        begin m1 <= in1; m3 <= m3 + 32'd1; end
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic drive(input logic r, input logic rn, input logic [31:0] d,
                       input logic [31:0] s, input logic [31:0] w);
    run = r; running = rn; delay0 = d; in0 = s; in1 = w;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({out0, out1, out2, out3} !== 128'd0) begin
      bad++; $display("FAIL reset_init: got %h %h %h %h want all 0", out0, out1, out2, out3);
    end
    rst = 1'b1;
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, $urandom, $urandom | 32'h1);
      @(negedge clk);
      total++;
      if ({out0, out1, out2, out3} !== {m0, m1, m2, m3}) begin
        bad++; $display("FAIL reset_pre: got %h %h %h %h want %h %h %h %h", out0, out1, out2, out3, m0, m1, m2, m3);
      end
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out0, out1, out2, out3} !== 128'd0) begin
      bad++; $display("FAIL reset_async: got %h %h %h %h want all 0", out0, out1, out2, out3);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, $urandom, $urandom);
      @(negedge clk);
      total++;
      if ({out0, out1, out2, out3} !== 128'd0) begin
        bad++; $display("FAIL reset_idle: got %h %h %h %h want all 0", out0, out1, out2, out3);
      end
    end
  endtask

  task automatic test_basic_split();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'hA); @(negedge clk);
    total++;
    if (out0 !== 32'hA) begin bad++; $display("FAIL basic_out0_a: got %h want a", out0); end
    drive(0, 1, 0, 0, 32'hB); @(negedge clk);
    total++;
    if (out1 !== 32'hB) begin bad++; $display("FAIL basic_out1_b: got %h want b", out1); end
    drive(0, 1, 0, 1, 32'hC); @(negedge clk);
    drive(0, 1, 0, 1, 32'hD); @(negedge clk);
    total++;
    if ({out0, out1, out2, out3} !== {32'hD, 32'hB, 32'd3, 32'd1}) begin
      bad++; $display("FAIL basic_final: got %h %h %h %h want d b 3 1", out0, out1, out2, out3);
    end
    total++;
    if ({out0, out1, out2, out3} !== {m0, m1, m2, m3}) begin
      bad++; $display("FAIL basic_model: got %h %h %h %h want %h %h %h %h", out0, out1, out2, out3, m0, m1, m2, m3);
    end
  endtask

  task automatic test_delay();
    drive(1, 1, 3, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, i[0], 32'h100 + i);
      @(negedge clk);
      total++;
      if ({out2, out3} !== 64'd0) begin
        bad++; $display("FAIL delay_ignored%0d: got %h %h want 0 0", i, out2, out3);
      end
    end
    drive(0, 1, 0, 0, 32'h44); @(negedge clk);
    total++;
    if ({out1, out2, out3} !== {32'h44, 32'd0, 32'd1}) begin
      bad++; $display("FAIL delay_first: got %h %h %h want 44 0 1", out1, out2, out3);
    end
  endtask

  task automatic test_restart();
    logic [31:0] h0, h1;
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, {31'd0, ~i[0]}, 32'h200 + i);
      @(negedge clk);
    end
    total++;
    if ({out0, out1, out2, out3} !== {32'h204, 32'h203, 32'd3, 32'd2}) begin
      bad++; $display("FAIL restart_pre: got %h %h %h %h want 204 203 3 2", out0, out1, out2, out3);
    end
    h0 = out0; h1 = out1;
    drive(1, 1, 0, 1, 32'hBAD);
    @(negedge clk);
    total++;
    if ({out0, out1, out2, out3} !== {h0, h1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL restart_clear: got %h %h %h %h want %h %h 0 0", out0, out1, out2, out3, h0, h1);
    end
    drive(0, 1, 0, 0, 32'h3C3C); @(negedge clk);
    total++;
    if ({out0, out1, out2, out3} !== {h0, 32'h3C3C, 32'd0, 32'd1}) begin
      bad++; $display("FAIL restart_resume: got %h %h %h %h want %h 3c3c 0 1", out0, out1, out2, out3, h0);
    end
  endtask

  task automatic test_running_drop();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h51); @(negedge clk);
    drive(0, 1, 0, 0, 32'h52); @(negedge clk);
    drive(0, 0, 0, 1, 32'h53); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, i[0], 32'h60 + i);
      @(negedge clk);
      total++;
      if ({out0, out1, out2, out3} !== {32'h51, 32'h52, 32'd1, 32'd1}) begin
        bad++; $display("FAIL drop_hold%0d: got %h %h %h %h want 51 52 1 1", i, out0, out1, out2, out3);
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 15) != 0),
            $urandom_range(0, 4), $urandom, $urandom);
      @(negedge clk);
      total++;
      if ({out0, out1, out2, out3} !== {m0, m1, m2, m3}) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random_c%0d: got %h %h %h %h want %h %h %h %h", i, out0, out1, out2, out3, m0, m1, m2, m3);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h70); @(negedge clk);
    force dut.out2 = 32'hFFFF_FFFE;
    release dut.out2;
    drive(0, 1, 0, 1, 32'h71); @(negedge clk);
    total++;
    if (out2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_max: got %h want ffffffff", out2); end
    drive(0, 1, 0, 32'hFFFF_FFFF, 32'h72); @(negedge clk);
    total++;
    if ({out0, out2} !== {32'h72, 32'h0}) begin
      bad++; $display("FAIL wrap_zero: got %h %h want 72 0", out0, out2);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_split();
    test_delay();
    test_restart();
    test_running_drop();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
